konw_arbiter: RTL and testbench

Sequential front end that shares a single two's-complement to sign-magnitude conversion datapath among NREQ requesters in the execution unit. Requesters offer operands with a valid/ready handshake; the block grants one, registers its operand, performs the conversion, and presents the tagged result with a valid/ready handshake toward the consumer. It flags the single unrepresentable input, the most negative value, as an error.

---
 rtl/konw_arbiter.sv | 135 +++++++++++++
 tb/tb_konw_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/konw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : konw_arbiter
// Purpose : Arbitrates NREQ requesters onto one two's-complement to
//           sign-magnitude converter and returns a tagged result with
//           valid/ready. Define KONW_ARB_RR_EN for round-robin arbitration
//           (fixed lowest-index priority otherwise).
// Revision: 1.0 - initial release
// ============================================================================
module konw_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rsn,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_res_valid,
    output logic [WIDTH-1:0]      o_res_data,
    output logic                  o_res_error,
    output logic [IDW-1:0]        o_res_id,
    input  logic                  i_res_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_operand;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   w_win_id;
    logic [IDW-1:0]   w_cand;
    logic             w_any_valid;
    logic             w_accept;
    logic [WIDTH-2:0] w_mag;
    logic [WIDTH-1:0] w_conv;
    logic             w_err;

`ifdef KONW_ARB_RR_EN
    logic [IDW-1:0] r_last_grant;

    // Search begins just after the previous winner and wraps around.
    always_comb begin
        w_win_id    = '0;
        w_any_valid = 1'b0;
        w_cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDW'((int'(r_last_grant) + i) % NREQ);
            if (!w_any_valid && i_req_valid[w_cand]) begin
                w_any_valid = 1'b1;
                w_win_id    = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_win_id;
        end
    end
`else
    always_comb begin
        w_win_id    = '0;
        w_any_valid = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDW'(i);
            if (!w_any_valid && i_req_valid[w_cand]) begin
                w_any_valid = 1'b1;
                w_win_id    = w_cand;
            end
        end
    end
`endif

    // Reset gates the grant so no requester sees an accept during reset cycles.
    assign w_accept = (r_state == S_IDLE) && i_rsn && w_any_valid;

    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            o_req_ready[k] = w_accept && (w_win_id == IDW'(k));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_CONV;
            S_CONV:   w_state_nxt = S_RESULT;
            S_RESULT: if (i_res_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The most negative value naturally converts to {1, zeros} and is flagged.
    assign w_mag  = r_operand[WIDTH-1] ? (~r_operand[WIDTH-2:0] + (WIDTH-1)'(1))
                                       : r_operand[WIDTH-2:0];
    assign w_conv = {r_operand[WIDTH-1], w_mag};
    assign w_err  = (r_operand == {1'b1, {(WIDTH-1){1'b0}}});

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            r_state     <= S_IDLE;
            r_operand   <= '0;
            r_grant_id  <= '0;
            o_res_data  <= '0;
            o_res_error <= 1'b0;
            o_res_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_operand  <= i_req_data[int'(w_win_id)*WIDTH +: WIDTH];
                r_grant_id <= w_win_id;
            end
            if (r_state == S_CONV) begin
                o_res_data  <= w_conv;
                o_res_error <= w_err;
                o_res_id    <= r_grant_id;
            end
        end
    end

    assign o_res_valid = (r_state == S_RESULT);

endmodule
`default_nettype wire

// File: tb/tb_konw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_konw_arbiter
// Purpose : Directed and randomized bench for konw_arbiter against a
//           transaction-level reference model. Honors KONW_ARB_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_konw_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  rsn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic                  res_error;
    logic [1:0]            res_id;
    logic                  res_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one operation in flight, aged in cycles since accept.
    int          last_grant;
    bit          in_flight;
    int          age;
    logic [31:0] pend_op;
    int          pend_id;
    logic [31:0] held_data;
    bit          held_err;
    int          held_id;
    logic [3:0]  last_accept;

    konw_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rsn       (rsn),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_res_valid (res_valid),
        .o_res_data  (res_data),
        .o_res_error (res_error),
        .o_res_id    (res_id),
        .i_res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v);
`ifdef KONW_ARB_RR_EN
        for (int off = 1; off <= NREQ; off++)
            if (v[(last_grant + off) % NREQ]) return (last_grant + off) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
`endif
        return -1;
    endfunction

    // Sign-magnitude by plain arithmetic: magnitude is |value| mod 2^31.
    function automatic logic [31:0] convert(input logic [31:0] a);
        longint mag;
        if (a[31] == 1'b0) return a;
        mag = (64'sd0 - longint'($signed(a))) % 64'sd2147483648;
        return 32'h8000_0000 | 32'(mag);
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h0000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // One clock: check at negedge, advance the model at posedge, return at +1.
    task automatic step();
        logic [3:0] exp_ready;
        int w;
        w = -1;
        @(negedge clk);
        exp_ready = '0;
        if (rsn && !in_flight) begin
            w = pick(req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("res_valid", res_valid, in_flight && age >= 2);
        chk("res_data", res_data, held_data);
        chk("res_error", res_error, held_err);
        chk("res_id", res_id, held_id);
        @(posedge clk);
        last_accept = '0;
        if (!rsn) begin
            in_flight  = 1'b0;
            held_data  = '0;
            held_err   = 1'b0;
            held_id    = 0;
            last_grant = NREQ - 1;
        end else if (!in_flight) begin
            if (w >= 0) begin
                in_flight      = 1'b1;
                age            = 1;
                pend_op        = req_data[w*WIDTH +: WIDTH];
                pend_id        = w;
                last_grant     = w;
                last_accept[w] = 1'b1;
            end
        end else if (age >= 2) begin
            if (res_ready) in_flight = 1'b0;
        end else begin
            age++;
            if (age == 2) begin
                held_data = convert(pend_op);
                held_err  = (pend_op == 32'h8000_0000);
                held_id   = pend_id;
            end
        end
        #1;
    endtask

    task automatic offer(input int k, input logic [31:0] val);
        req_valid    = '0;
        req_valid[k] = 1'b1;
        req_data[k*WIDTH +: WIDTH] = val;
        step();
        req_valid = '0;
        repeat (3) step();
    endtask

    initial begin
        rsn         = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        res_ready   = 1'b0;
        last_grant  = NREQ - 1;
        in_flight   = 1'b0;
        age         = 0;
        pend_op     = '0;
        pend_id     = 0;
        held_data   = '0;
        held_err    = 1'b0;
        held_id     = 0;
        last_accept = '0;
        @(posedge clk);
        #1;

        // Reset with every requester asking
        req_valid = 4'hF;
        repeat (2) step();
        rsn       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        step();

        // Positive, negative and most-negative operands
        offer(2, 32'h0000_0005);
        offer(0, 32'hFFFF_FFFB);
        offer(0, 32'h8000_0000);

        // Back-pressure with competing requests, then reset mid-result
        res_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 32'h1234_5678;
        step();
        req_valid = 4'b1101;
        repeat (7) step();
        rsn = 1'b0;
        step();
        rsn       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        step();

        // Arbitration order with all requesters held valid
        for (int k = 0; k < NREQ; k++) req_data[k*WIDTH +: WIDTH] = 32'(-(k + 1));
        req_valid = 4'hF;
        repeat (15) step();
        req_valid = '0;
        step();

        // Randomized traffic; pending requesters keep valid and data until granted
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || last_accept[k]) begin
                    req_valid[k] = 1'($urandom_range(0, 1));
                    req_data[k*WIDTH +: WIDTH] = rand_op();
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            rsn       = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
